correlator_scheduler: RTL and testbench
=======================================

CORRELATOR_SCHEDULER -- requirements
Module: correlator_scheduler

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 36: number of RESOLUTION-bit payload words per packet.
REQ-002 SHALL have parameter RESOLUTION, default 24: payload word width in bits; a multiple of 4.
REQ-003 SHALL have parameter INTEG_WIDTH, default 32: width of the integration-length input.
REQ-004 SHALL have port pllclk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: run request for integrate/readout cycles.
REQ-007 SHALL have port integ_cycles, input, INTEG_WIDTH: integration length in pllclk cycles, sampled on entry to INTEGRATE.
REQ-008 SHALL have port ovf_in, input, 1: correlator overflow indication; OR-ed into a sticky per-frame flag.
REQ-009 SHALL have port word_addr, output, 16: payload word index requested from the correlator.
REQ-010 SHALL have port word_data, input, RESOLUTION: word at word_addr, valid one cycle after word_addr changes.
REQ-011 SHALL have port acc_hold, output, 1: freezes the correlator accumulators while high.
REQ-012 SHALL have port acc_clear, output, 1: one-cycle accumulator clear strobe.
REQ-013 SHALL have port out_data, output, 4: output nibble.
REQ-014 SHALL have port out_valid, output, 1: out_data valid.
REQ-015 SHALL have port out_ready, input, 1: sink accepts the nibble; transfer occurs when out_valid and out_ready are both high.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, INTEGRATE, FETCH, HEADER, PAYLOAD, FOOTER.
- IDLE -> CLEAR when enable=1.
- CLEAR: acc_clear=1 for exactly 1 cycle, then -> INTEGRATE.
REQ-018 INTEGRATE SHALL hold acc_hold=0 for exactly max(integ_cycles,1) cycles, then -> HEADER with acc_hold=1.
REQ-019 acc_hold SHALL stay 1 from HEADER entry through the last FOOTER transfer; in IDLE and CLEAR it SHALL be 1.
REQ-020 The packet SHALL consist of a 64-bit header, then NUM_WORDS words, then a 64-bit footer, sent MSB nibble first.
- Header = {16'hA4C5, 15'd0, ovf_flag, frame_cnt[31:0]}.
- Payload words are sent in order 0..NUM_WORDS-1, RESOLUTION/4 nibbles each.
- Footer = {checksum[31:0], 32'h5A5AA5A5}, where checksum is the mod-2^32 sum of all payload words, zero-extended.
REQ-021 Before each word, FETCH SHALL drive word_addr for 1 cycle (out_valid=0), capture word_data on the next cycle, then -> PAYLOAD.
REQ-022 out_data and out_valid SHALL remain stable until the nibble is accepted, and the nibble index SHALL advance only on a transfer.
REQ-023 After the last footer nibble is accepted: if enable=1 -> CLEAR, with frame_cnt incremented (wraps at 2^32); otherwise -> IDLE, with frame_cnt also incremented.
REQ-024 Deassertion of enable SHALL NOT abort INTEGRATE or readout; the frame completes first.
REQ-025 ovf_flag SHALL be set by ovf_in=1 during INTEGRATE and cleared in CLEAR.
REQ-026 A new integ_cycles value SHALL take effect only at the next INTEGRATE entry.

Reset
REQ-027 While reset=0 (sampled at a pllclk edge), the block SHALL enter IDLE with: acc_hold=1, acc_clear=0, out_valid=0, out_data=0, word_addr=0, busy=0, frame_cnt=0, ovf_flag=0, checksum=0.
REQ-028 Reset mid-packet SHALL abandon the packet immediately with no further nibbles, and the first packet after reset SHALL carry frame_cnt=0.

Structure
REQ-029 A shared package SHALL hold the state enum, HEADER_SYNC=16'hA4C5 and FOOTER_SYNC=32'h5A5AA5A5.
REQ-030 A sub-module nibble_serializer SHALL handle 64-bit/RESOLUTION-bit load, MSB-first shift and the valid/ready handshake; all other logic SHALL be in the top.

Verification
REQ-031 Scenario: reset=0 for 3 cycles then 1, enable=0 -> busy=0, acc_hold=1, out_valid=0 indefinitely.
REQ-032 Scenario: enable=1, integ_cycles=10, NUM_WORDS=2, words 0x000001 and 0x000002, out_ready=1 -> one acc_clear pulse, then 10 cycles of acc_hold=0, then nibbles A4C5 0000 00000000 000001 000002 00000003 5A5AA5A5.
REQ-033 Scenario: integ_cycles=0 -> exactly 1 cycle of acc_hold=0.
REQ-034 Scenario: out_ready toggled randomly -> identical nibble sequence, with each nibble held stable while stalled.
REQ-035 Scenario: ovf_in pulsed once in INTEGRATE -> header bit 32 = 1 in that frame and 0 in the next; frame_cnt reads 0, then 1.
REQ-036 Scenario: enable dropped mid-PAYLOAD -> packet completes, then IDLE; reset=0 mid-HEADER -> out_valid=0 on the next cycle.

Source files
------------

// File: rtl/correlator_scheduler_pkg.sv
// Shared definitions for the correlator readout scheduler: FSM states and
// the packet framing constants.
package correlator_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        INTEGRATE,
        FETCH,
        HEADER,
        PAYLOAD,
        FOOTER
    } state_t;

    localparam logic [15:0] HEADER_SYNC = 16'hA4C5;
    localparam logic [31:0] FOOTER_SYNC = 32'h5A5AA5A5;

endpackage

// File: rtl/correlator_scheduler_nibble_serializer.sv
// Shifts a 64-bit frame word or a RESOLUTION-bit payload word out MSB nibble
// first over a valid/ready handshake.
module nibble_serializer #(
    parameter int RESOLUTION = 24
) (
    input  logic        pllclk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        wide_i,
    input  logic [63:0] data_i,
    input  logic        out_ready_i,
    output logic [3:0]  out_data_o,
    output logic        out_valid_o,
    output logic        last_o
);

    localparam logic [4:0] WORD_NIBBLES = 5'(RESOLUTION / 4);

    logic [63:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic        xfer;

    assign xfer        = valid_q && out_ready_i;
    assign last_o      = xfer && (count_q == 5'd1);
    assign out_data_o  = shift_q[63:60];
    assign out_valid_o = valid_q;

    // Payload words arrive right-aligned and are left-aligned so the MSB
    // nibble always sits at the top of the shifter.
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = wide_i ? data_i : (data_i << (64 - RESOLUTION));
            count_d = wide_i ? 5'd16 : WORD_NIBBLES;
            valid_d = 1'b1;
        end else if (xfer) begin
            shift_d = {shift_q[59:0], 4'h0};
            count_d = count_q - 5'd1;
            if (count_q == 5'd1) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pllclk) begin
        if (!reset) begin
            shift_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/correlator_scheduler.sv
// Sequences clear/integrate/readout cycles of the correlator and frames the
// accumulator contents into header/payload/footer nibble packets.
module correlator_scheduler #(
    parameter int NUM_WORDS   = 36,
    parameter int RESOLUTION  = 24,
    parameter int INTEG_WIDTH = 32
) (
    input  logic                   pllclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INTEG_WIDTH-1:0] integ_cycles,
    input  logic                   ovf_in,
    output logic [15:0]            word_addr,
    input  logic [RESOLUTION-1:0]  word_data,
    output logic                   acc_hold,
    output logic                   acc_clear,
    output logic [3:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    import correlator_scheduler_pkg::*;

    state_t                 state_q, state_d;
    logic [INTEG_WIDTH-1:0] integ_cnt_q, integ_cnt_d;
    logic [15:0]            word_idx_q, word_idx_d;
    logic                   fetch_phase_q, fetch_phase_d;
    logic [31:0]            checksum_q, checksum_d;
    logic [31:0]            frame_cnt_q, frame_cnt_d;
    logic                   ovf_flag_q, ovf_flag_d;

    logic                   ser_load;
    logic                   ser_wide;
    logic [63:0]            ser_data;
    logic                   ser_last;

    assign word_addr = word_idx_q;
    assign acc_hold  = (state_q != INTEGRATE);
    assign acc_clear = (state_q == CLEAR);
    assign busy      = (state_q != IDLE);

    nibble_serializer #(
        .RESOLUTION (RESOLUTION)
    ) u_serializer (
        .pllclk      (pllclk),
        .reset       (reset),
        .load_i      (ser_load),
        .wide_i      (ser_wide),
        .data_i      (ser_data),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .last_o      (ser_last)
    );

    always_comb begin
        state_d       = state_q;
        integ_cnt_d   = integ_cnt_q;
        word_idx_d    = word_idx_q;
        fetch_phase_d = fetch_phase_q;
        checksum_d    = checksum_q;
        frame_cnt_d   = frame_cnt_q;
        ovf_flag_d    = ovf_flag_q;
        ser_load      = 1'b0;
        ser_wide      = 1'b1;
        ser_data      = '0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                word_idx_d  = '0;
                checksum_d  = '0;
                ovf_flag_d  = 1'b0;
                integ_cnt_d = (integ_cycles == '0) ? INTEG_WIDTH'(1) : integ_cycles;
                state_d     = INTEGRATE;
            end
            INTEGRATE: begin
                if (ovf_in) begin
                    ovf_flag_d = 1'b1;
                end
                // An overflow in the final integration cycle still lands in this header.
                if (integ_cnt_q == INTEG_WIDTH'(1)) begin
                    state_d  = HEADER;
                    ser_load = 1'b1;
                    ser_data = {HEADER_SYNC, 15'd0, ovf_flag_q | ovf_in, frame_cnt_q};
                end else begin
                    integ_cnt_d = integ_cnt_q - INTEG_WIDTH'(1);
                end
            end
            HEADER: begin
                if (ser_last) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Phase 0 presents the address; word_data is valid in phase 1.
                fetch_phase_d = ~fetch_phase_q;
                if (fetch_phase_q) begin
                    ser_load   = 1'b1;
                    ser_wide   = 1'b0;
                    ser_data   = 64'(word_data);
                    checksum_d = checksum_q + 32'(word_data);
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (ser_last) begin
                    if (word_idx_q == 16'(NUM_WORDS - 1)) begin
                        state_d  = FOOTER;
                        ser_load = 1'b1;
                        ser_data = {checksum_q, FOOTER_SYNC};
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                        state_d    = FETCH;
                    end
                end
            end
            FOOTER: begin
                if (ser_last) begin
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = enable ? CLEAR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pllclk) begin
        if (!reset) begin
            state_q       <= IDLE;
            integ_cnt_q   <= '0;
            word_idx_q    <= '0;
            fetch_phase_q <= 1'b0;
            checksum_q    <= '0;
            frame_cnt_q   <= '0;
            ovf_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            integ_cnt_q   <= integ_cnt_d;
            word_idx_q    <= word_idx_d;
            fetch_phase_q <= fetch_phase_d;
            checksum_q    <= checksum_d;
            frame_cnt_q   <= frame_cnt_d;
            ovf_flag_q    <= ovf_flag_d;
        end
    end

endmodule

// File: tb/tb_correlator_scheduler.sv
// Self-checking bench for correlator_scheduler: packets are predicted from
// the framing rules and compared nibble by nibble against the DUT stream.
module tb_correlator_scheduler;

    logic        pllclk;
    logic        reset;
    logic        enable;
    logic [31:0] integ_cycles;
    logic        ovf_in;
    logic [15:0] word_addr;
    logic [23:0] word_data;
    logic        acc_hold;
    logic        acc_clear;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [23:0] mem [2];
    int          vectors;
    int          miscompares;
    logic [31:0] fcnt;

    correlator_scheduler #(
        .NUM_WORDS   (2),
        .RESOLUTION  (24),
        .INTEG_WIDTH (32)
    ) dut (
        .pllclk       (pllclk),
        .reset        (reset),
        .enable       (enable),
        .integ_cycles (integ_cycles),
        .ovf_in       (ovf_in),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .acc_hold     (acc_hold),
        .acc_clear    (acc_clear),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    initial pllclk = 1'b0;
    always #5 pllclk = ~pllclk;

    // Correlator memory model: data follows the address by one cycle.
    always @(posedge pllclk)
        word_data <= (word_addr < 16'd2) ? mem[word_addr[0]] : 24'hBADBAD;

    // Runs one frame starting at the negedge where CLEAR should be visible and
    // returns at the negedge after the final footer nibble was accepted.
    task automatic run_packet(input int integ, input bit rand_ready,
                              input int ovf_at, input int drop_at);
        logic [3:0]  q[$];
        logic [63:0] hdr;
        logic [63:0] ftr;
        logic [23:0] w;
        logic [31:0] sum;
        logic [3:0]  held;
        bit          held_valid;
        bit          ovf_exp;
        int          exp_len, clr, h0, n, cyc;
        exp_len = (integ == 0) ? 1 : integ;
        ovf_exp = (ovf_at >= 1) && (ovf_at <= exp_len);
        sum     = 32'(mem[0]) + 32'(mem[1]);
        hdr     = {16'hA4C5, 15'd0, ovf_exp, fcnt};
        ftr     = {sum, 32'h5A5AA5A5};
        for (int i = 15; i >= 0; i--) q.push_back(hdr[i*4 +: 4]);
        for (int k = 0; k < 2; k++) begin
            w = mem[k];
            for (int i = 5; i >= 0; i--) q.push_back(w[i*4 +: 4]);
        end
        for (int i = 15; i >= 0; i--) q.push_back(ftr[i*4 +: 4]);
        held_valid = 0; held = 4'h0;
        clr = 0; h0 = 0; n = 0; cyc = 0;
        while (q.size() > 0 && cyc < 3000) begin
            if (acc_clear === 1'b1) clr++;
            if (acc_hold === 1'b0) h0++;
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL busy_in_frame cycle %0d: got %b want 1", cyc, busy);
            end
            if (held_valid) begin
                vectors++;
                if ({out_valid, out_data} !== {1'b1, held}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold nibble %0d: got v=%b d=%h want v=1 d=%h",
                             n, out_valid, out_data, held);
                end
            end
            ovf_in       = (acc_hold === 1'b0) && (h0 == ovf_at);
            integ_cycles = (cyc == 0) ? 32'(integ) : 32'($urandom_range(0, 40));
            out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop_at >= 0 && n == drop_at) enable = 1'b0;
            held_valid = (out_valid === 1'b1) && !out_ready;
            held       = out_data;
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (out_data !== q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL nibble %0d frame %0d: got %h want %h", n, fcnt, out_data, q[0]);
                end
                void'(q.pop_front());
                n++;
            end
            @(posedge pllclk);
            @(negedge pllclk);
            cyc++;
        end
        ovf_in = 1'b0;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL packet_timeout: got %0d nibbles want %0d", n, n + q.size());
        end
        vectors++;
        if (clr != 1) begin
            miscompares++;
            $display("[TB] FAIL clear_pulses: got %0d want 1", clr);
        end
        vectors++;
        if (h0 != exp_len) begin
            miscompares++;
            $display("[TB] FAIL integ_length integ=%0d: got %0d want %0d", integ, h0, exp_len);
        end
        fcnt = fcnt + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; out_ready = 1'b1; ovf_in = 1'b0; integ_cycles = 32'd5;
        repeat (3) @(negedge pllclk);
        reset = 1'b1;
        fcnt  = 32'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pllclk);
            vectors++;
            if ({busy, acc_hold, acc_clear, out_valid, out_data, word_addr} !==
                {1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0}) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cycle %0d: got busy=%b hold=%b clr=%b v=%b d=%h a=%h want 0 1 0 0 0 0",
                         i, busy, acc_hold, acc_clear, out_valid, out_data, word_addr);
            end
        end
    endtask

    task automatic test_basic();
        mem[0] = 24'h000001;
        mem[1] = 24'h000002;
        enable = 1'b1;
        @(negedge pllclk);
        run_packet(10, 1'b0, 0, 20);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({busy, acc_hold, out_valid} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL basic_idle cycle %0d: got %b want 010", i, {busy, acc_hold, out_valid});
            end
            @(negedge pllclk);
        end
    endtask

    task automatic test_integ_zero();
        mem[0] = 24'($urandom());
        mem[1] = 24'($urandom());
        enable = 1'b1;
        @(negedge pllclk);
        run_packet(0, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({busy, acc_hold, out_valid} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL zero_idle cycle %0d: got %b want 010", i, {busy, acc_hold, out_valid});
            end
            @(negedge pllclk);
        end
    endtask

    task automatic test_stall();
        for (int f = 0; f < 3; f++) begin
            mem[0] = 24'($urandom());
            mem[1] = 24'($urandom());
            enable = 1'b1;
            @(negedge pllclk);
            run_packet(int'($urandom_range(1, 20)), 1'b1, 0, int'($urandom_range(0, 40)));
            vectors++;
            if ({busy, acc_hold, out_valid} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL stall_idle frame %0d: got %b want 010", f, {busy, acc_hold, out_valid});
            end
            @(negedge pllclk);
        end
    endtask

    task automatic test_mid_reset();
        int seen, cyc;
        mem[0] = 24'($urandom());
        mem[1] = 24'($urandom());
        enable = 1'b1; integ_cycles = 32'd3; out_ready = 1'b1;
        @(negedge pllclk);
        seen = 0; cyc = 0;
        while (seen < 4 && cyc < 100) begin
            if (out_valid === 1'b1) seen++;
            @(posedge pllclk);
            @(negedge pllclk);
            cyc++;
        end
        vectors++;
        if (seen < 4) begin
            miscompares++;
            $display("[TB] FAIL midreset_wait: got %0d nibbles want 4", seen);
        end
        reset = 1'b0; enable = 1'b0;
        @(negedge pllclk);
        vectors++;
        if ({busy, acc_hold, out_valid, out_data, word_addr} !== {3'b010, 4'h0, 16'h0}) begin
            miscompares++;
            $display("[TB] FAIL midreset_abort: got busy=%b hold=%b v=%b d=%h a=%h want 0 1 0 0 0",
                     busy, acc_hold, out_valid, out_data, word_addr);
        end
        reset = 1'b1;
        fcnt  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pllclk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_quiet cycle %0d: got %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_ovf_back_to_back();
        mem[0] = 24'($urandom());
        mem[1] = 24'($urandom());
        enable = 1'b1;
        @(negedge pllclk);
        run_packet(int'($urandom_range(2, 12)), 1'b1, 2, -1);
        mem[0] = 24'($urandom());
        mem[1] = 24'($urandom());
        run_packet(int'($urandom_range(1, 12)), 1'b1, 0, 16 + int'($urandom_range(0, 11)));
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({busy, acc_hold, out_valid} !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL b2b_idle cycle %0d: got %b want 010", i, {busy, acc_hold, out_valid});
            end
            @(negedge pllclk);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        fcnt         = 32'd0;
        mem[0]       = 24'h0;
        mem[1]       = 24'h0;
        reset        = 1'b0;
        enable       = 1'b0;
        integ_cycles = 32'd0;
        ovf_in       = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_basic();
        test_integ_zero();
        test_stall();
        test_mid_reset();
        test_ovf_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
